alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_seq_iter.sv | 98 +++++++++
 rtl/alu_seq.sv | 136 +++++++++++++
 tb/tb_alu_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and opcode helpers for the sequential ALU.
// Optional divider is enabled by defining ALU_SEQ_DIV_EN.
package alu_pkg;

  localparam logic [5:0] OP_AND = 6'b000000;
  localparam logic [5:0] OP_OR  = 6'b000001;
  localparam logic [5:0] OP_ADD = 6'b000010;
  localparam logic [5:0] OP_XOR = 6'b000011;
  localparam logic [5:0] OP_SUB = 6'b000110;
  localparam logic [5:0] OP_SLT = 6'b000111;
  localparam logic [5:0] OP_DIV = 6'b001110;
  localparam logic [5:0] OP_MUL = 6'b001111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } alu_state_e;

  // Opcodes that run through the iterative datapath instead of the one-cycle path.
  function automatic logic is_multi(input logic [5:0] op);
`ifdef ALU_SEQ_DIV_EN
    return (op == OP_MUL) || (op == OP_DIV);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative shift/accumulate datapath: shift-add multiply and, with
// ALU_SEQ_DIV_EN, restoring divide. Runs WIDTH steps after start_i.
module alu_seq_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
`ifdef ALU_SEQ_DIV_EN
  input  logic               div_i,
`endif
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] acc_o
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q, opd_d;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step;
`ifdef ALU_SEQ_DIV_EN
  logic               div_q, div_d;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_fits;
`endif

  // MUL: acc = {partial, multiplier}; add multiplicand to the top half, shift right.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    step    = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    // DIV: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opd_q};
    div_fits  = !div_diff[WIDTH+1];
    if (div_q) begin
      step = {(div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
              acc_q[WIDTH-2:0], div_fits};
    end
`endif
  end

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    acc_d  = acc_q;
    opd_d  = opd_q;
`ifdef ALU_SEQ_DIV_EN
    div_d  = div_q;
`endif
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(WIDTH - 1);
      acc_d  = {{WIDTH{1'b0}}, b_i};
      opd_d  = a_i;
`ifdef ALU_SEQ_DIV_EN
      div_d  = div_i;
      if (div_i) begin
        acc_d = {{WIDTH{1'b0}}, a_i};
        opd_d = b_i;
      end
`endif
    end else if (busy_q) begin
      acc_d = step;
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      acc_q  <= '0;
      opd_q  <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q  <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      acc_q  <= acc_d;
      opd_q  <= opd_d;
`ifdef ALU_SEQ_DIV_EN
      div_q  <= div_d;
`endif
    end
  end

  assign done_o = busy_q && (cnt_q == '0);
  assign acc_o  = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready on both sides and registered outputs.
// Define ALU_SEQ_DIV_EN to add the unsigned restoring divider (ctrl 001110).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             illegal,
  output alu_state_e       dbg_state
);
  // Handshake: a side transfers on any rising edge where its valid and ready are
  // both high; out_valid holds with stable outputs until out_ready is seen.
  alu_state_e         state_q, state_d;
  logic               accept, start, done, load;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   ld_res, ld_hi;
  logic               ld_carry, ld_ill, ld_zero;
  logic               out_valid_q;
  logic [WIDTH-1:0]   res_q, hi_q;
  logic               carry_q, zero_q, ill_q;
`ifdef ALU_SEQ_DIV_EN
  logic               is_div_q, dz_q;
`endif

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
`ifdef ALU_SEQ_DIV_EN
    .div_i   (ctrl == OP_DIV),
`endif
    .a_i     (a),
    .b_i     (b),
    .done_o  (done),
    .acc_o   (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ITER;
      ITER:    if (done)  state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    start    = accept && is_multi(ctrl);
    load     = (accept && !is_multi(ctrl)) || (state_q == FIN);
    ld_res   = '0;
    ld_hi    = '0;
    ld_carry = 1'b0;
    ld_ill   = 1'b0;
    if (state_q == FIN) begin
      ld_res   = acc[WIDTH-1:0];
      ld_hi    = acc[2*WIDTH-1:WIDTH];
      ld_carry = |acc[2*WIDTH-1:WIDTH];
`ifdef ALU_SEQ_DIV_EN
      if (is_div_q) ld_carry = dz_q;
`endif
    end else begin
      case (ctrl)
        OP_AND:  ld_res = a & b;
        OP_OR:   ld_res = a | b;
        OP_XOR:  ld_res = a ^ b;
        OP_ADD:  {ld_carry, ld_res} = {1'b0, a} + {1'b0, b};
        OP_SUB:  {ld_carry, ld_res} = {1'b0, a} - {1'b0, b};
        OP_SLT:  ld_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        default: ld_ill = 1'b1;
      endcase
    end
    ld_zero = ~|{ld_carry, ld_hi, ld_res};
  end

`ifdef ALU_SEQ_DIV_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
    end else if (start) begin
      is_div_q <= (ctrl == OP_DIV);
      dz_q     <= (b == '0);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
      hi_q        <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b1;
      ill_q       <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      res_q       <= ld_res;
      hi_q        <= ld_hi;
      carry_q     <= ld_carry;
      zero_q      <= ld_zero;
      ill_q       <= ld_ill;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = res_q;
  assign result_hi = hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign illegal   = ill_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): vector table, hand-written
// multi-cycle corner sequences and randomised traffic through a scoreboard.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int EW = 2 * W + 3;

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         il;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic         carry, zero, illegal;
  logic [W-1:0] a, b, result, result_hi;
  logic [5:0]   ctrl;
  alu_state_e   dbg_state;

  int           n_cmp  = 0;
  int           n_fail = 0;
  int           n_deliv = 0;
  bit           bp_en = 1'b0;
  logic [EW-1:0] exp_q[$];
  vec_t         tbl[14];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ctrl      (ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .zero      (zero),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack(input logic il, input logic c,
                                         input logic [W-1:0] hi, input logic [W-1:0] res);
    return {il, c, ({c, hi, res} == '0), hi, res};
  endfunction

  function automatic logic [EW-1:0] model(input logic [5:0] op, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [2*W-1:0] p;
    logic [W:0]     s;
    logic [W-1:0]   lt;
    case (op)
      OP_AND: return pack(1'b0, 1'b0, '0, x & y);
      OP_OR:  return pack(1'b0, 1'b0, '0, x | y);
      OP_XOR: return pack(1'b0, 1'b0, '0, x ^ y);
      OP_ADD: begin
        s = {1'b0, x} + {1'b0, y};
        return pack(1'b0, s[W], '0, s[W-1:0]);
      end
      OP_SUB: return pack(1'b0, (x < y), '0, x - y);
      OP_SLT: begin
        lt = '0;
        lt[0] = ($signed(x) < $signed(y));
        return pack(1'b0, 1'b0, '0, lt);
      end
      OP_MUL: begin
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        return pack(1'b0, |p[2*W-1:W], p[2*W-1:W], p[W-1:0]);
      end
`ifdef ALU_SEQ_DIV_EN
      OP_DIV: begin
        if (y == '0) return pack(1'b0, 1'b1, x, '1);
        return pack(1'b0, 1'b0, x % y, x / y);
      end
`endif
      default: return pack(1'b1, 1'b0, '0, '0);
    endcase
  endfunction

  // Scoreboard: every delivered result is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_deliv++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h with no expectation queued",
                 {illegal, carry, zero, result_hi, result});
      end else begin
        chk("result", 64'({illegal, carry, zero, result_hi, result}), 64'(exp_q.pop_front()));
      end
    end
  end

  always @(posedge clk) begin
    if (bp_en) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [5:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [EW-1:0] e, input bit push);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    ctrl = op;
    a = x;
    b = y;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
    end else if (push) begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    ctrl = 6'($urandom_range(0, 63));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [EW-1:0] snap;
    logic [5:0]    rop;
    int            cycles;
    int            base;
    bit            seen;

    tbl[0]  = '{OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{OP_AND, 16'h00F0, 16'h0F00, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{OP_OR,  16'h0001, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{OP_XOR, 16'hA5A5, 16'hFFFF, 16'h5A5A, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{OP_SLT, 16'h8000, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{OP_SLT, 16'h0001, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{OP_ADD, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{OP_SUB, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{6'b101010, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{OP_MUL, 16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0};
`ifdef ALU_SEQ_DIV_EN
    tbl[12] = '{OP_DIV, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0, 1'b0};
    tbl[13] = '{OP_DIV, 16'd5,    16'd0,    16'hFFFF, 16'd5,    1'b1, 1'b0, 1'b0};
`else
    tbl[12] = '{OP_DIV, 16'd100,  16'd7,    16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{OP_DIV, 16'd5,    16'd0,    16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
`endif

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    ctrl = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_outputs", 64'({illegal, carry, zero, result_hi, result}), 64'(pack(1'b0, 1'b0, '0, '0)));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_state", 64'(dbg_state), 64'(IDLE));

    // Vector table, back-to-back with out_ready held high.
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b,
           {tbl[i].il, tbl[i].c, tbl[i].z, tbl[i].hi, tbl[i].res}, 1'b1);
    end
    drain();

    // Back-to-back single-cycle ops deliver on consecutive cycles.
    base = n_deliv;
    send(OP_AND, 16'h00F0, 16'h0F00, pack(1'b0, 1'b0, '0, '0), 1'b1);
    send(OP_OR, 16'h0001, 16'h0000, pack(1'b0, 1'b0, '0, 16'h0001), 1'b1);
    @(negedge clk);
    #2;
    chk("b2b_deliveries", 64'(n_deliv - base), 64'(2));
    drain();

    // MUL latency, in_ready low while busy, and output hold under backpressure.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(OP_MUL, 16'hFFFF, 16'hFFFF, pack(1'b0, 1'b1, 16'hFFFE, 16'h0001), 1'b1);
    cycles = 0;
    @(negedge clk);
    while (!out_valid && cycles < 100) begin
      chk("mul_busy_in_ready", 64'(in_ready), 64'(0));
      cycles++;
      @(negedge clk);
    end
    chk("mul_latency", 64'(cycles), 64'(17));
    snap = {illegal, carry, zero, result_hi, result};
    chk("mul_first_value", 64'(snap), 64'(pack(1'b0, 1'b1, 16'hFFFE, 16'h0001)));
    repeat (3) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'(1));
      chk("hold_stable", 64'({illegal, carry, zero, result_hi, result}), 64'(snap));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // in_valid during ITER/FIN must not be accepted.
    send(OP_MUL, 16'h0003, 16'h0005, pack(1'b0, 1'b0, '0, 16'h000F), 1'b1);
    in_valid = 1'b1;
    ctrl = OP_ADD;
    a = 16'h0001;
    b = 16'h0001;
    repeat (10) begin
      @(negedge clk);
      chk("iter_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a MUL aborts it without a result.
    send(OP_MUL, 16'h1234, 16'h0010, '0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 64'(seen), 64'(0));
    chk("abort_state", 64'(dbg_state), 64'(IDLE));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    send(OP_ADD, 16'h0001, 16'h0001, pack(1'b0, 1'b0, '0, 16'h0002), 1'b1);
    drain();

    // Randomised traffic with random backpressure.
    bp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 8))
        0: rop = OP_AND;
        1: rop = OP_OR;
        2: rop = OP_ADD;
        3: rop = OP_XOR;
        4: rop = OP_SUB;
        5: rop = OP_SLT;
        6: rop = OP_MUL;
        7: rop = OP_DIV;
        default: rop = 6'($urandom_range(16, 63));
      endcase
      a = W'($urandom);
      b = (i % 7 == 0) ? '0 : W'($urandom);
      send(rop, a, b, model(rop, a, b), 1'b1);
    end
    bp_en = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
